// File: rtl/aes_sload_pkg.sv
// Shared constants and types for the AES block loader: column count,
// the byte-array state form fed to the round datapath, and loader FSM states.
package aes_sload_pkg;
    localparam int Nb     = 4;
    localparam int NBYTES = 4 * Nb;
    localparam int WCNT_W = $clog2(Nb);
    localparam int CNT_W  = $clog2(Nb) + 1;

    // Byte 0 is the most-significant byte of the packed vector.
    typedef logic [0:NBYTES-1][7:0] aes_state_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } sload_state_t;
endpackage

// File: rtl/aes_sload_if.sv
// Word-in / block-out bus of the AES block loader.
// Handshake: a word moves on in_valid && in_ready, a block on out_valid && out_ready,
// both sampled at the rising clock edge; the producer must hold data stable while valid.
interface aes_sload_if;
    import aes_sload_pkg::*;

    logic                   clear;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_data;
    logic                   out_valid;
    logic                   out_ready;
    aes_state_t             out_data;
    logic [CNT_W-1:0]       out_cnt;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_cnt
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_cnt
    );
endinterface

// File: rtl/aes_sload.sv
// Assembles Nb big-endian 32-bit column words into the AES byte-array state.
// The buffer can accept word 0 of the next block in the cycle the current one is taken.
module aes_sload
    import aes_sload_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    aes_sload_if.slave   bus,
    output sload_state_t dbg_state
);
    sload_state_t      state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    aes_state_t        data_q;
    logic              in_ready;
    logic [CNT_W-1:0]  out_cnt;
    logic              word_xfer;
    logic              blk_xfer;

    always_comb begin
        in_ready  = 1'b0;
        out_cnt   = '0;
        state_nxt = state;
        wcnt_nxt  = wcnt;

        case (state)
            FILL: begin
                in_ready = !bus.clear;
                out_cnt  = CNT_W'(wcnt);
            end
            FULL: begin
                in_ready = bus.out_ready && !bus.clear;
                out_cnt  = CNT_W'(Nb);
            end
            default: ;
        endcase

        word_xfer = bus.in_valid && in_ready;
        blk_xfer  = (state == FULL) && bus.out_ready && !bus.clear;

        if (bus.clear) begin
            state_nxt = FILL;
            wcnt_nxt  = '0;
        end else begin
            case (state)
                FILL: begin
                    if (word_xfer) begin
                        if (wcnt == WCNT_W'(Nb - 1)) begin
                            state_nxt = FULL;
                            wcnt_nxt  = '0;
                        end else begin
                            wcnt_nxt = wcnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    // A word arriving with the block hand-off lands in column 0.
                    if (blk_xfer) begin
                        state_nxt = FILL;
                        wcnt_nxt  = word_xfer ? WCNT_W'(1) : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FILL;
            wcnt   <= '0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (word_xfer) begin
                case (wcnt)
                    2'd0: data_q[0:3]   <= bus.in_data;
                    2'd1: data_q[4:7]   <= bus.in_data;
                    2'd2: data_q[8:11]  <= bus.in_data;
                    2'd3: data_q[12:15] <= bus.in_data;
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_cnt   = out_cnt;
    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = data_q;
    assign dbg_state     = state;
endmodule
